alarm: RTL and testbench

// - Intrusion-alarm controller: asserts notify when the system is armed (set=1) and door or window sensor is open.
// - Core truth table: notify = set & (door | window); all other input combinations give notify=0.
// - Sits between raw sensor/keyswitch pins and the siren/indicator driver.
// - Inputs are synchronised and debounced; outputs are registered.

---
 rtl/alarm_pkg.sv | 14 +
 rtl/alarm_debounce.sv | 53 +++++
 rtl/alarm.sv | 114 +++++++++++
 tb/tb_alarm.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and constants for the intrusion-alarm controller.
package alarm_pkg;

   typedef enum logic [1:0] {
      DISARMED = 2'd0,
      ARMED    = 2'd1,
      ALARM    = 2'd2
   } state_t;

   localparam int unsigned ZONE_DOOR   = 1;
   localparam int unsigned ZONE_WINDOW = 0;
   localparam int unsigned ZONE_W      = 2;

endpackage

// File: rtl/alarm_debounce.sv
// Input synchroniser followed by a consecutive-cycle counter filter.
// The filtered value follows the synchronised input only after the two have
// differed for DEBOUNCE_CYCLES consecutive cycles; any match restarts the count.
// DEBOUNCE_CYCLES = 0 bypasses the filter.
module alarm_debounce #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned CNT_W           = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   synced;

   // Multi-flop synchroniser for the asynchronous sensor pin
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync <= '0;
      else     sync <= {sync[SYNC_STAGES-2:0], din};
   end

   assign synced = sync[SYNC_STAGES-1];

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_no_filter
         assign dout = synced;
      end else begin : g_filter
         logic [CNT_W-1:0] cnt;
         logic             filt;

         // Accept a change only after DEBOUNCE_CYCLES consecutive differing samples
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               cnt  <= '0;
               filt <= 1'b0;
            end else if (synced == filt) begin
               cnt  <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               filt <= synced;
               cnt  <= '0;
            end else begin
               cnt  <= cnt + CNT_W'(1);
            end
         end

         assign dout = filt;
      end
   endgenerate

endmodule

// File: rtl/alarm.sv
// Intrusion-alarm controller: notify = armed & (door | window).
// set is synchronised only; door and window are synchronised and debounced.
// Optional macro ALARM_LATCH_EN: ALARM becomes sticky until disarm, and zone
// accumulates every sensor that tripped while in ALARM.
module alarm
   import alarm_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned CNT_W           = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              set,
   input  logic              door,
   input  logic              window,
   output logic              notify,
   output logic              armed,
   output logic [ZONE_W-1:0] zone
);

   logic [SYNC_STAGES-1:0] set_sync;
   logic                   s_set;
   logic                   fdoor;
   logic                   fwindow;
   logic                   trig;

   state_t            state;
   state_t            state_next;
   logic              notify_next;
   logic              armed_next;
   logic [ZONE_W-1:0] zone_next;

   // Arm-switch synchroniser (no debounce on the keyswitch)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) set_sync <= '0;
      else     set_sync <= {set_sync[SYNC_STAGES-2:0], set};
   end

   assign s_set = set_sync[SYNC_STAGES-1];

   alarm_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_door_db (
      .clk  (clk),
      .rst  (rst),
      .din  (door),
      .dout (fdoor)
   );

   alarm_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_window_db (
      .clk  (clk),
      .rst  (rst),
      .din  (window),
      .dout (fwindow)
   );

   assign trig = fdoor | fwindow;

   // State register plus output registers loaded from the next state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= DISARMED;
         notify <= 1'b0;
         armed  <= 1'b0;
         zone   <= '0;
      end else begin
         state  <= state_next;
         notify <= notify_next;
         armed  <= armed_next;
         zone   <= zone_next;
      end
   end

   // Next-state logic; disarm overrides everything
   always_comb begin
      state_next = state;
      if (!s_set) begin
         state_next = DISARMED;
      end else begin
         case (state)
            DISARMED: state_next = trig ? ALARM : ARMED;
            ARMED:    if (trig) state_next = ALARM;
`ifdef ALARM_LATCH_EN
            ALARM:    state_next = ALARM;
`else
            ALARM:    if (!trig) state_next = ARMED;
`endif
            default:  state_next = DISARMED;
         endcase
      end
   end

   // Output decode from the next state
   always_comb begin
      notify_next = (state_next == ALARM);
      armed_next  = (state_next != DISARMED);
      zone_next   = '0;
      if (state_next == ALARM) begin
         zone_next[ZONE_DOOR]   = fdoor;
         zone_next[ZONE_WINDOW] = fwindow;
`ifdef ALARM_LATCH_EN
         if (state == ALARM) zone_next = zone_next | zone;
`endif
      end
   end

endmodule

// File: tb/tb_alarm.sv
// Self-checking bench for the alarm controller (default parameters).
// Expected {notify, armed, zone} values are pushed to a scoreboard queue when
// stimulus is applied and popped when the DUT output is sampled.
module tb_alarm;

   logic       clk;
   logic       rst;
   logic       set;
   logic       door;
   logic       window;
   logic       notify;
   logic       armed;
   logic [1:0] zone;

   int vectors;
   int miscompares;

   logic [3:0] sb[$];
   logic [3:0] exp_v;
   logic [3:0] obs_v;

`ifdef ALARM_LATCH_EN
   localparam bit LATCH = 1'b1;
`else
   localparam bit LATCH = 1'b0;
`endif

   alarm dut (
      .clk    (clk),
      .rst    (rst),
      .set    (set),
      .door   (door),
      .window (window),
      .notify (notify),
      .armed  (armed),
      .zone   (zone)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive(input logic s, input logic d, input logic w);
      set    = s;
      door   = d;
      window = w;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0);
      sb.push_back(4'b0000);
      tick(1);
      exp_v = sb.pop_front();
      obs_v = {notify, armed, zone};
      vectors++;
      if (obs_v !== exp_v) begin
         miscompares++;
         $display("FAIL reset_state: got %b expected %b", obs_v, exp_v);
      end
      rst = 1'b0;
      tick(5);
   endtask

   task automatic test_truth_table;
      logic s, d, w, n;
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'b0, 1'b0);
         tick(20);
         s = i[2];
         d = i[1];
         w = i[0];
         n = s & (d | w);
         drive(s, d, w);
         sb.push_back({n, s, n ? {d, w} : 2'b00});
         tick(20);
         exp_v = sb.pop_front();
         obs_v = {notify, armed, zone};
         vectors++;
         if (obs_v !== exp_v) begin
            miscompares++;
            $display("FAIL truth_table sdw=%0d%0d%0d: got %b expected %b", s, d, w, obs_v, exp_v);
         end
      end
      drive(1'b0, 1'b0, 1'b0);
      tick(20);
   endtask

   task automatic test_latency;
      drive(1'b1, 1'b0, 1'b0);
      tick(20);
      door = 1'b1;
      sb.push_back(4'b0100);
      sb.push_back(4'b1110);
      tick(6);
      exp_v = sb.pop_front();
      obs_v = {notify, armed, zone};
      vectors++;
      if (obs_v !== exp_v) begin
         miscompares++;
         $display("FAIL door_latency_cycle6: got %b expected %b", obs_v, exp_v);
      end
      tick(1);
      exp_v = sb.pop_front();
      obs_v = {notify, armed, zone};
      vectors++;
      if (obs_v !== exp_v) begin
         miscompares++;
         $display("FAIL door_latency_cycle7: got %b expected %b", obs_v, exp_v);
      end
      tick(5);
      set = 1'b0;
      sb.push_back(4'b1110);
      sb.push_back(4'b0000);
      tick(2);
      exp_v = sb.pop_front();
      obs_v = {notify, armed, zone};
      vectors++;
      if (obs_v !== exp_v) begin
         miscompares++;
         $display("FAIL set_latency_cycle2: got %b expected %b", obs_v, exp_v);
      end
      tick(1);
      exp_v = sb.pop_front();
      obs_v = {notify, armed, zone};
      vectors++;
      if (obs_v !== exp_v) begin
         miscompares++;
         $display("FAIL set_latency_cycle3: got %b expected %b", obs_v, exp_v);
      end
      drive(1'b0, 1'b0, 1'b0);
      tick(20);
   endtask

   task automatic test_bounce;
      drive(1'b1, 1'b0, 1'b0);
      tick(20);
      window = 1'b1;
      tick(3);
      window = 1'b0;
      for (int c = 0; c < 12; c++) begin
         sb.push_back(4'b0100);
         tick(1);
         exp_v = sb.pop_front();
         obs_v = {notify, armed, zone};
         vectors++;
         if (obs_v !== exp_v) begin
            miscompares++;
            $display("FAIL bounce_3cyc t=%0d: got %b expected %b", c, obs_v, exp_v);
         end
      end
      window = 1'b1;
      sb.push_back(4'b1101);
      tick(4);
      window = 1'b0;
      tick(3);
      exp_v = sb.pop_front();
      obs_v = {notify, armed, zone};
      vectors++;
      if (obs_v !== exp_v) begin
         miscompares++;
         $display("FAIL bounce_4cyc: got %b expected %b", obs_v, exp_v);
      end
      drive(1'b0, 1'b0, 1'b0);
      tick(20);
   endtask

   task automatic test_latch;
      drive(1'b1, 1'b0, 1'b0);
      tick(20);
      door = 1'b1;
      tick(10);
      door = 1'b0;
      sb.push_back(LATCH ? 4'b1110 : 4'b0100);
      tick(20);
      exp_v = sb.pop_front();
      obs_v = {notify, armed, zone};
      vectors++;
      if (obs_v !== exp_v) begin
         miscompares++;
         $display("FAIL latch_after_close: got %b expected %b", obs_v, exp_v);
      end
      window = 1'b1;
      sb.push_back(LATCH ? 4'b1111 : 4'b1101);
      tick(20);
      exp_v = sb.pop_front();
      obs_v = {notify, armed, zone};
      vectors++;
      if (obs_v !== exp_v) begin
         miscompares++;
         $display("FAIL latch_zone_accum: got %b expected %b", obs_v, exp_v);
      end
      set = 1'b0;
      sb.push_back(4'b0000);
      tick(10);
      exp_v = sb.pop_front();
      obs_v = {notify, armed, zone};
      vectors++;
      if (obs_v !== exp_v) begin
         miscompares++;
         $display("FAIL latch_disarm: got %b expected %b", obs_v, exp_v);
      end
      drive(1'b0, 1'b0, 1'b0);
      tick(20);
   endtask

   task automatic test_async_reset;
      drive(1'b1, 1'b1, 1'b0);
      tick(20);
      sb.push_back(4'b1110);
      exp_v = sb.pop_front();
      obs_v = {notify, armed, zone};
      vectors++;
      if (obs_v !== exp_v) begin
         miscompares++;
         $display("FAIL pre_reset_alarm: got %b expected %b", obs_v, exp_v);
      end
      #2;
      rst = 1'b1;
      sb.push_back(4'b0000);
      #1;
      exp_v = sb.pop_front();
      obs_v = {notify, armed, zone};
      vectors++;
      if (obs_v !== exp_v) begin
         miscompares++;
         $display("FAIL async_reset_clear: got %b expected %b", obs_v, exp_v);
      end
      tick(2);
      rst = 1'b0;
      sb.push_back(4'b0000);
      tick(1);
      exp_v = sb.pop_front();
      obs_v = {notify, armed, zone};
      vectors++;
      if (obs_v !== exp_v) begin
         miscompares++;
         $display("FAIL post_reset_disarmed: got %b expected %b", obs_v, exp_v);
      end
      sb.push_back(4'b1110);
      tick(20);
      exp_v = sb.pop_front();
      obs_v = {notify, armed, zone};
      vectors++;
      if (obs_v !== exp_v) begin
         miscompares++;
         $display("FAIL post_reset_realarm: got %b expected %b", obs_v, exp_v);
      end
      drive(1'b0, 1'b0, 1'b0);
      tick(20);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_truth_table();
      test_latency();
      test_bounce();
      test_latch();
      test_async_reset();
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
